// File: rtl/cursor_overlay_if.sv
// Pixel-stream and control bundle for the hardware cursor overlay.
// The pixel stream has no back-pressure: every clock carries one pixel, in and out.
interface cursor_overlay_if #(
  parameter int COORD_W = 10,
  parameter int RGB_W   = 12,
  parameter int CUR_W   = 16,
  parameter int CUR_H   = 16
);
  localparam int ROW_W = (CUR_H > 1) ? $clog2(CUR_H) : 1;

  logic               frame_start;
  logic [COORD_W-1:0] mouse_x;
  logic [COORD_W-1:0] mouse_y;
  logic               cur_en;
  logic               blink_en;
  logic               bm_we;
  logic [ROW_W-1:0]   bm_row;
  logic [2*CUR_W-1:0] bm_wdata;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic               de_in;
  logic [RGB_W-1:0]   rgb_in;
  logic               de_out;
  logic [RGB_W-1:0]   rgb_out;

  modport master (
    output frame_start, mouse_x, mouse_y, cur_en, blink_en,
    output bm_we, bm_row, bm_wdata,
    output vga_x, vga_y, de_in, rgb_in,
    input  de_out, rgb_out
  );

  modport slave (
    input  frame_start, mouse_x, mouse_y, cur_en, blink_en,
    input  bm_we, bm_row, bm_wdata,
    input  vga_x, vga_y, de_in, rgb_in,
    output de_out, rgb_out
  );
endinterface

// File: rtl/cursor_overlay.sv
// Hardware cursor overlay: 2bpp bitmap drawn at a frame-latched mouse position,
// hotspot offset, edge clipping without wrap, optional blink, 2-cycle pixel pipeline.
module cursor_overlay #(
  parameter int              COORD_W      = 10,
  parameter int              RGB_W        = 12,
  parameter int              CUR_W        = 16,
  parameter int              CUR_H        = 16,
  parameter int              HOT_X        = 0,
  parameter int              HOT_Y        = 0,
  parameter logic [RGB_W-1:0] FG_COLOR    = 12'hFFF,
  parameter logic [RGB_W-1:0] OL_COLOR    = 12'h000,
  parameter int              BLINK_FRAMES = 30
) (
  input logic             clk,
  input logic             reset,
  cursor_overlay_if.slave bus
);
  localparam int S_W   = COORD_W + 2;
  localparam int ROW_W = (CUR_H > 1) ? $clog2(CUR_H) : 1;
  localparam int COL_W = (CUR_W > 1) ? $clog2(CUR_W) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic signed [S_W-1:0] HOT_X_S = S_W'(HOT_X);
  localparam logic signed [S_W-1:0] HOT_Y_S = S_W'(HOT_Y);
  localparam logic signed [S_W-1:0] CUR_W_S = S_W'(CUR_W);
  localparam logic signed [S_W-1:0] CUR_H_S = S_W'(CUR_H);

  // Shadow rows are written at any time; active rows only change at frame_start.
  logic [2*CUR_W-1:0] shadow [CUR_H];
  logic [2*CUR_W-1:0] active [CUR_H];

  logic [COORD_W-1:0] mx_lat;
  logic [COORD_W-1:0] my_lat;
  logic               en_lat;
  logic [BLK_W-1:0]   blink_cnt;
  logic               visible;

  logic               row_ok;
  logic signed [S_W-1:0] ox, oy, dx, dy;
  logic               hit;
  logic [COL_W-1:0]   dx_idx;
  logic [ROW_W-1:0]   dy_idx;
  logic [2*CUR_W-1:0] row_bits;
  logic [1:0]         code;

  logic               s1_show;
  logic [1:0]         s1_code;
  logic [RGB_W-1:0]   s1_rgb;
  logic               s1_de;
  logic [RGB_W-1:0]   pix;

  assign row_ok = (32'(bus.bm_row) < CUR_H);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < CUR_H; r++) shadow[r] <= '0;
    end else if (bus.bm_we && row_ok) begin
      shadow[bus.bm_row] <= bus.bm_wdata;
    end
  end

  // Nonblocking copy takes the pre-write shadow, so a write in the commit cycle waits a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < CUR_H; r++) active[r] <= '0;
      mx_lat <= '0;
      my_lat <= '0;
      en_lat <= 1'b0;
    end else if (bus.frame_start) begin
      for (int r = 0; r < CUR_H; r++) active[r] <= shadow[r];
      mx_lat <= bus.mouse_x;
      my_lat <= bus.mouse_y;
      en_lat <= bus.cur_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (!bus.blink_en) begin
      blink_cnt <= '0;
      visible   <= 1'b1;
    end else if (bus.frame_start) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        visible   <= ~visible;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Two spare bits keep origin and offsets exact: no modulo-2^COORD_W wrap.
  always_comb begin
    ox       = $signed({2'b00, mx_lat}) - HOT_X_S;
    oy       = $signed({2'b00, my_lat}) - HOT_Y_S;
    dx       = $signed({2'b00, bus.vga_x}) - ox;
    dy       = $signed({2'b00, bus.vga_y}) - oy;
    hit      = !dx[S_W-1] && (dx < CUR_W_S) && !dy[S_W-1] && (dy < CUR_H_S);
    dx_idx   = dx[COL_W-1:0];
    dy_idx   = dy[ROW_W-1:0];
    row_bits = '0;
    code     = 2'b00;
    if (hit) begin
      row_bits = active[dy_idx];
      code     = row_bits[{dx_idx, 1'b0} +: 2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_show <= 1'b0;
      s1_code <= 2'b00;
      s1_rgb  <= '0;
      s1_de   <= 1'b0;
    end else begin
      s1_show <= hit && en_lat && visible;
      s1_code <= code;
      s1_rgb  <= bus.rgb_in;
      s1_de   <= bus.de_in;
    end
  end

  always_comb begin
    pix = s1_rgb;
    if (!s1_de) begin
      pix = '0;
    end else if (s1_show) begin
      case (s1_code)
        2'b01:   pix = FG_COLOR;
        2'b10:   pix = OL_COLOR;
        2'b11:   pix = ~s1_rgb;
        default: pix = s1_rgb;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.de_out  <= 1'b0;
      bus.rgb_out <= '0;
    end else begin
      bus.de_out  <= s1_de;
      bus.rgb_out <= pix;
    end
  end
endmodule

// File: tb/tb_cursor_overlay.sv
// Bench for cursor_overlay: directed scenarios plus random traffic, all checked
// against a screen-level model of cursor geometry, frame commit and blink.
module tb_cursor_overlay;
  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;
  localparam int CUR_W   = 16;
  localparam int CUR_H   = 12;
  localparam int HOT_X   = 4;
  localparam int HOT_Y   = 4;
  localparam logic [RGB_W-1:0] FG = 12'hFFF;
  localparam logic [RGB_W-1:0] OL = 12'h000;
  localparam int BLINK   = 2;
  localparam int ROW_W   = (CUR_H > 1) ? $clog2(CUR_H) : 1;

  typedef logic [RGB_W:0] out_t;

  logic clk;
  logic reset;

  cursor_overlay_if #(.COORD_W(COORD_W), .RGB_W(RGB_W), .CUR_W(CUR_W), .CUR_H(CUR_H)) ifc ();

  cursor_overlay #(
    .COORD_W(COORD_W), .RGB_W(RGB_W), .CUR_W(CUR_W), .CUR_H(CUR_H),
    .HOT_X(HOT_X), .HOT_Y(HOT_Y), .FG_COLOR(FG), .OL_COLOR(OL), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [1:0] shadow_m [CUR_H][CUR_W];
  logic [1:0] active_m [CUR_H][CUR_W];
  int   mx_m, my_m, nfs_m;
  bit   en_m;
  logic [RGB_W:0] exp_q[$];
  out_t exp_now;
  int   vectors, miscompares;

  function automatic out_t model_pix();
    int dx, dy;
    bit vis;
    logic [1:0] c;
    if (!ifc.de_in) return '0;
    dx  = int'(ifc.vga_x) - (mx_m - HOT_X);
    dy  = int'(ifc.vga_y) - (my_m - HOT_Y);
    vis = ((nfs_m / BLINK) % 2) == 0;
    if (dx < 0 || dx >= CUR_W || dy < 0 || dy >= CUR_H || !en_m || !vis)
      return {1'b1, ifc.rgb_in};
    c = active_m[dy][dx];
    case (c)
      2'b01:   return {1'b1, FG};
      2'b10:   return {1'b1, OL};
      2'b11:   return {1'b1, ~ifc.rgb_in};
      default: return {1'b1, ifc.rgb_in};
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < CUR_H; r++)
      for (int c = 0; c < CUR_W; c++) begin
        shadow_m[r][c] = 2'b00;
        active_m[r][c] = 2'b00;
      end
    mx_m = 0; my_m = 0; en_m = 0; nfs_m = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic fs, we, ben, cen;
    logic [ROW_W-1:0] row;
    logic [2*CUR_W-1:0] wd;
    int mx, my;
    exp_q.push_back(model_pix());
    fs = ifc.frame_start; we = ifc.bm_we; row = ifc.bm_row; wd = ifc.bm_wdata;
    ben = ifc.blink_en; cen = ifc.cur_en;
    mx = int'(ifc.mouse_x); my = int'(ifc.mouse_y);
    @(posedge clk);
    #1;
    if (fs) begin
      active_m = shadow_m;
      mx_m = mx; my_m = my; en_m = cen;
    end
    if (we && int'(row) < CUR_H)
      for (int c = 0; c < CUR_W; c++) shadow_m[row][c] = wd[2*c +: 2];
    if (!ben) nfs_m = 0;
    else if (fs) nfs_m++;
    exp_now = exp_q.pop_front();
  endtask

  task automatic idle_inputs();
    ifc.frame_start = 1'b0;
    ifc.bm_we       = 1'b0;
    ifc.bm_row      = '0;
    ifc.bm_wdata    = '0;
    ifc.de_in       = 1'b0;
    ifc.vga_x       = '0;
    ifc.vga_y       = '0;
    ifc.rgb_in      = '0;
  endtask

  task automatic set_pix(input int x, input int y, input bit de, input logic [RGB_W-1:0] rgb);
    ifc.vga_x  = COORD_W'(x);
    ifc.vga_y  = COORD_W'(y);
    ifc.de_in  = de;
    ifc.rgb_in = rgb;
  endtask

  task automatic write_row(input int row, input logic [2*CUR_W-1:0] data);
    idle_inputs();
    ifc.bm_we    = 1'b1;
    ifc.bm_row   = ROW_W'(row);
    ifc.bm_wdata = data;
    cycle();
    idle_inputs();
  endtask

  task automatic commit(input int mx, input int my, input bit en);
    idle_inputs();
    ifc.mouse_x     = COORD_W'(mx);
    ifc.mouse_y     = COORD_W'(my);
    ifc.cur_en      = en;
    ifc.frame_start = 1'b1;
    cycle();
    idle_inputs();
  endtask

  // Leaves the DUT output holding the result for this one pixel.
  task automatic probe(input int x, input int y, input bit de, input logic [RGB_W-1:0] rgb);
    idle_inputs();
    set_pix(x, y, de, rgb);
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ifc.mouse_x = '0; ifc.mouse_y = '0; ifc.cur_en = 1'b0; ifc.blink_en = 1'b0;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ifc.de_out !== 1'b0 || ifc.rgb_out !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got de=%b rgb=%h want de=0 rgb=000", ifc.de_out, ifc.rgb_out);
    end
    model_reset();
    reset = 1'b1;
    ifc.cur_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_pix($urandom_range(0, 30), $urandom_range(0, 30), 1'b1, RGB_W'($urandom));
      cycle();
      vectors++;
      if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
        miscompares++;
        $display("FAIL reset_passthru: got %h want %h", {ifc.de_out, ifc.rgb_out}, exp_now);
      end
    end
  endtask

  task automatic test_basic();
    logic [RGB_W-1:0] r;
    write_row(0, {CUR_W{2'b01}});
    commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
    for (int y = 50; y <= 51; y++)
      for (int x = 96; x <= 120; x++) begin
        set_pix(x, y, 1'b1, RGB_W'($urandom));
        cycle();
        vectors++;
        if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
          miscompares++;
          $display("FAIL basic_scan: got %h want %h", {ifc.de_out, ifc.rgb_out}, exp_now);
        end
      end
    r = 12'h5C3;
    probe(100, 50, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL basic_left_edge: got %h want %h", ifc.rgb_out, FG);
    end
    probe(115, 50, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL basic_right_edge: got %h want %h", ifc.rgb_out, FG);
    end
    probe(99, 50, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL basic_x99: got %h want %h", ifc.rgb_out, r);
    end
    probe(116, 50, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL basic_x116: got %h want %h", ifc.rgb_out, r);
    end
    probe(100, 51, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL basic_row51: got %h want %h", ifc.rgb_out, r);
    end
  endtask

  task automatic test_codes();
    logic [RGB_W-1:0] want [4];
    want[0] = 12'h3A5; want[1] = 12'hFFF; want[2] = 12'h000; want[3] = 12'hC5A;
    write_row(0, 32'h0000_00E4);
    for (int r = CUR_H; r < 16; r++) write_row(r, {CUR_W{2'b11}});
    commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i < 4) set_pix(100 + i, 50, 1'b1, 12'h3A5);
      cycle();
      if (i >= 1 && i <= 4) begin
        vectors++;
        if ({ifc.de_out, ifc.rgb_out} !== {1'b1, want[i-1]}) begin
          miscompares++;
          $display("FAIL code_col%0d: got %h want %h", i - 1, ifc.rgb_out, want[i-1]);
        end
      end
    end
    for (int i = 0; i < 60; i++) begin
      set_pix($urandom_range(95, 120), $urandom_range(45, 65), 1'b1, RGB_W'($urandom));
      cycle();
      vectors++;
      if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
        miscompares++;
        $display("FAIL codes_scan: got %h want %h", {ifc.de_out, ifc.rgb_out}, exp_now);
      end
    end
  endtask

  task automatic test_clip();
    logic [RGB_W-1:0] r;
    r = 12'h1E7;
    for (int row = 0; row < CUR_H; row++) write_row(row, {CUR_W{2'b01}});
    commit(2, 1, 1'b1);
    probe(0, 0, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL clip_origin: got %h want %h", ifc.rgb_out, FG);
    end
    probe(13, 0, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL clip_x13: got %h want %h", ifc.rgb_out, FG);
    end
    probe(14, 0, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL clip_x14: got %h want %h", ifc.rgb_out, r);
    end
    probe(1023, 1023, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL clip_nowrap_low: got %h want %h", ifc.rgb_out, r);
    end
    for (int i = 0; i < 80; i++) begin
      set_pix($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(1000, 1023),
              $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(1000, 1023),
              1'b1, RGB_W'($urandom));
      cycle();
      vectors++;
      if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
        miscompares++;
        $display("FAIL clip_scan_tl: got %h want %h", {ifc.de_out, ifc.rgb_out}, exp_now);
      end
    end
    commit(1023, 1023, 1'b1);
    probe(1023, 1023, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL clip_corner: got %h want %h", ifc.rgb_out, FG);
    end
    probe(0, 0, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL clip_nowrap_high: got %h want %h", ifc.rgb_out, r);
    end
    for (int i = 0; i < 80; i++) begin
      set_pix($urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(1000, 1023),
              $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(1000, 1023),
              1'b1, RGB_W'($urandom));
      cycle();
      vectors++;
      if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
        miscompares++;
        $display("FAIL clip_scan_br: got %h want %h", {ifc.de_out, ifc.rgb_out}, exp_now);
      end
    end
  endtask

  task automatic test_frame_sync();
    logic [RGB_W-1:0] r;
    r = 12'h2B4;
    for (int row = 0; row < CUR_H; row++) write_row(row, {CUR_W{2'b01}});
    commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
    ifc.mouse_x = 10'd200;
    ifc.mouse_y = 10'd200;
    write_row(0, {CUR_W{2'b11}});
    probe(100, 50, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL sync_old_pos: got %h want %h", ifc.rgb_out, FG);
    end
    probe(196, 196, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL sync_new_pos_early: got %h want %h", ifc.rgb_out, r);
    end
    // Pixel in the commit cycle still uses the old frame; the next pixel uses the new one.
    idle_inputs();
    ifc.frame_start = 1'b1;
    set_pix(100, 50, 1'b1, r);
    cycle();
    idle_inputs();
    set_pix(100, 50, 1'b1, r);
    cycle();
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL sync_commit_cycle: got %h want %h", ifc.rgb_out, FG);
    end
    idle_inputs();
    cycle();
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL sync_after_commit: got %h want %h", ifc.rgb_out, r);
    end
    probe(196, 196, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== ~r) begin
      miscompares++; $display("FAIL sync_new_row0: got %h want %h", ifc.rgb_out, ~r);
    end
    idle_inputs();
    ifc.frame_start = 1'b1;
    ifc.bm_we = 1'b1; ifc.bm_row = ROW_W'(1); ifc.bm_wdata = {CUR_W{2'b10}};
    cycle();
    probe(196, 197, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL sync_coincident_write: got %h want %h", ifc.rgb_out, FG);
    end
    commit(200, 200, 1'b1);
    probe(196, 197, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== OL) begin
      miscompares++; $display("FAIL sync_deferred_write: got %h want %h", ifc.rgb_out, OL);
    end
  endtask

  task automatic test_blink();
    logic [5:0] pattern;
    logic [RGB_W-1:0] r;
    pattern = 6'b110011;
    ifc.blink_en = 1'b0;
    for (int row = 0; row < CUR_H; row++) write_row(row, {CUR_W{2'b01}});
    commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
    ifc.blink_en = 1'b1;
    for (int f = 0; f < 7; f++) begin
      if (f > 0) commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
      r = RGB_W'($urandom_range(1, 4094));
      probe(105, 52, 1'b1, r);
      vectors++;
      if (ifc.rgb_out !== (((f < 6) ? pattern[f] : 1'b0) ? FG : r)) begin
        miscompares++;
        $display("FAIL blink_frame%0d: got %h want %h", f, ifc.rgb_out,
                 ((f < 6) ? pattern[f] : 1'b0) ? FG : r);
      end
    end
    r = 12'h777;
    idle_inputs();
    ifc.blink_en = 1'b0;
    set_pix(105, 52, 1'b1, r);
    cycle();
    set_pix(106, 52, 1'b1, r);
    cycle();
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL blink_off_same_cycle: got %h want %h", ifc.rgb_out, r);
    end
    idle_inputs();
    cycle();
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL blink_restore: got %h want %h", ifc.rgb_out, FG);
    end
  endtask

  task automatic test_passthrough_reset();
    logic [RGB_W-1:0] r;
    r = 12'h9D1;
    probe(105, 52, 1'b0, r);
    vectors++;
    if (ifc.de_out !== 1'b0 || ifc.rgb_out !== '0) begin
      miscompares++;
      $display("FAIL de_low: got de=%b rgb=%h want de=0 rgb=000", ifc.de_out, ifc.rgb_out);
    end
    set_pix(105, 52, 1'b1, r);
    cycle();
    cycle();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (ifc.de_out !== 1'b0 || ifc.rgb_out !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got de=%b rgb=%h want de=0 rgb=000", ifc.de_out, ifc.rgb_out);
    end
    do_reset();
    write_row(5, {CUR_W{2'b01}});
    probe(100, 55, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL hidden_after_reset: got %h want %h", ifc.rgb_out, r);
    end
    commit(100 + HOT_X, 50 + HOT_Y, 1'b0);
    probe(100, 55, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== r) begin
      miscompares++; $display("FAIL hidden_cur_en0: got %h want %h", ifc.rgb_out, r);
    end
    commit(100 + HOT_X, 50 + HOT_Y, 1'b1);
    probe(100, 55, 1'b1, r);
    vectors++;
    if (ifc.rgb_out !== FG) begin
      miscompares++; $display("FAIL shown_cur_en1: got %h want %h", ifc.rgb_out, FG);
    end
  endtask

  task automatic test_back_to_back();
    int bx, by;
    bx = 300; by = 200;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) ifc.blink_en = ($urandom_range(0, 3) != 0);
      ifc.frame_start = ($urandom_range(0, 39) == 0);
      if (ifc.frame_start) begin
        bx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
        by = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 40);
        ifc.mouse_x = COORD_W'(bx);
        ifc.mouse_y = COORD_W'(by);
        ifc.cur_en  = ($urandom_range(0, 4) != 0);
      end
      ifc.bm_we    = ($urandom_range(0, 7) == 0);
      ifc.bm_row   = ROW_W'($urandom_range(0, 15));
      ifc.bm_wdata = {$urandom, $urandom};
      set_pix((bx + $urandom_range(0, 40) - 20) & 1023, (by + $urandom_range(0, 40) - 20) & 1023,
              ($urandom_range(0, 9) != 0), RGB_W'($urandom));
      cycle();
      vectors++;
      if ({ifc.de_out, ifc.rgb_out} !== exp_now) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h want %h", i, {ifc.de_out, ifc.rgb_out}, exp_now);
      end
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_codes();
    test_clip();
    test_frame_sync();
    test_blink();
    test_passthrough_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Parametrised hardware-cursor overlay in the VGA pixel pipeline, between the background/sprite compositor and the DAC output register.
- Draws a CUR_W x CUR_H cursor at the latched mouse position, with these features:
  - 2-bit-per-pixel bitmap supporting transparent, foreground, outline and inverse pixels.
  - Hotspot offset.
  - Edge clipping with no wrap-around.
  - Frame-synchronous position and bitmap update.
  - Optional blink.
- Two-cycle pipelined pass-through of RGB and display-enable.

Parameters:
- COORD_W, 10, width of all screen coordinates.
- RGB_W, 12, pixel colour width.
- CUR_W, 16, cursor width in pixels (1..32).
- CUR_H, 16, cursor height in pixels (1..32).
- HOT_X, 0, hotspot column inside the bitmap (< CUR_W).
- HOT_Y, 0, hotspot row inside the bitmap (< CUR_H).
- FG_COLOR, 12'hFFF, colour for code 01.
- OL_COLOR, 12'h000, colour for code 10.
- BLINK_FRAMES, 30, frames per blink half-period (>= 1).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- mouse_x  in  COORD_W  mouse hotspot x.
- mouse_y  in  COORD_W  mouse hotspot y.
- cur_en  in  1  cursor enable, sampled at frame_start.
- blink_en  in  1  blink enable, level.
- bm_we  in  1  bitmap row write strobe.
- bm_row  in  clog2(CUR_H)  row index to write.
- bm_wdata  in  2*CUR_W  row data; bits [2i+1:2i] are column i, column 0 is leftmost.
- vga_x  in  COORD_W  current pixel x.
- vga_y  in  COORD_W  current pixel y.
- de_in  in  1  display enable.
- rgb_in  in  RGB_W  upstream pixel.
- de_out  out  1  de_in delayed by 2 cycles.
- rgb_out  out  RGB_W  composited pixel.

Behaviour:
- Reset (reset=0, async):
  - rgb_out=0, de_out=0, all pipeline registers 0.
  - Shadow and active bitmaps all 00 (transparent).
  - Latched position 0, latched enable 0.
  - Blink counter 0, visible=1.
- Bitmap write:
  - bm_we=1 writes bm_wdata into shadow row bm_row.
  - bm_row >= CUR_H: the write is ignored.
- Frame commit, on frame_start=1:
  - Active bitmap <= shadow, taken before any same-cycle write. A write coinciding with frame_start commits at the next frame_start.
  - Latched mx/my <= mouse_x/mouse_y.
  - Latched enable <= cur_en.
  - Position and bitmap are therefore stable for a whole frame; no tearing.
- Geometry:
  - Origin ox = mx - HOT_X, oy = my - HOT_Y, computed signed at COORD_W+2 bits.
  - dx = vga_x - ox, dy = vga_y - oy, signed.
  - Hit when 0 <= dx < CUR_W and 0 <= dy < CUR_H.
  - Negative origins clip at the left and top edges. Coordinates never wrap modulo 2^COORD_W.
  - Pixels beyond the screen are simply never scanned.
- Blink counter:
  - Increments on each frame_start while blink_en=1.
  - On reaching BLINK_FRAMES-1 it clears to 0 and visible toggles.
  - blink_en=0 forces counter=0 and visible=1 on the next clock.
- Pipeline, latency exactly 2 cycles:
  - Stage 1 registers: hit, code = active[dy][dx] (2 bits), rgb_in, de_in.
  - Stage 2 registers: de_out = stage-1 de, and rgb_out:
    - de=0: 0.
    - not (hit & latched enable & visible): rgb_in passes through.
    - code 00: rgb_in.
    - code 01: FG_COLOR.
    - code 10: OL_COLOR.
    - code 11: bitwise NOT of rgb_in.
- Timing of changes:
  - A frame_start in cycle t affects hit/code evaluation from cycle t+1.
  - The corresponding output changes appear from cycle t+3 onward.
- Reset mid-frame: outputs go to 0 immediately; after release, the cursor is hidden until the first frame_start with cur_en=1.

Test Plan:
1. Reset release, cur_en=1:
   - Stimulus: write row 0 = all 01, frame_start, mouse=(100,50), scan.
   - Response: (100..115,50) -> 12'hFFF at 2-cycle latency; (99,50), (116,50) and row 51 pass rgb_in.
2. Codes:
   - Stimulus: row 0 columns 0..3 = 00,01,10,11, rgb_in=12'h3A5.
   - Response: outputs 3A5, FFF, 000, C5A.
3. Hotspot and clip:
   - Stimulus: HOT_X=HOT_Y=4, mouse=(2,1), bitmap all 01.
   - Response: cursor covers x 0..13, y 0..12. Nothing drawn at x>=1020 or y>=1020 (no wrap).
4. Frame-synchronous update:
   - Stimulus: change mouse to (200,200) and write rows mid-frame.
   - Response: output unchanged until after next frame_start. A bm_we coinciding with frame_start appears only after the following frame_start.
5. Blink:
   - Stimulus: BLINK_FRAMES=2, blink_en=1, 6 frames.
   - Response: visibility pattern on, on, off, off, on, on. Deasserting blink_en restores visible on the next clock.
6. Pass-through and reset:
   - Stimulus: de_in=0 inside cursor area.
   - Response: rgb_out=0, de_out=0.
   - Stimulus: assert reset mid-line.
   - Response: rgb_out=0 asynchronously; cursor hidden until frame_start with cur_en=1.
